// File: rtl/simon_pkg.sv
// Shared types and widths for the Simon player-input path.
package simon_pkg;

  localparam int unsigned LED_W  = 4;
  localparam int unsigned VAL_W  = 2;
  localparam int unsigned ADDR_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_PRESS,
    ST_WAIT_RELEASE,
    ST_PASS,
    ST_FAIL
  } chk_state_e;

  // Index of the set bit of a one-hot button vector (bit k -> value k).
  function automatic logic [VAL_W-1:0] onehot_index(input logic [LED_W-1:0] v);
    logic [VAL_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < LED_W; i++) begin
      if (v[i]) idx = VAL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser followed by a stable-count debouncer for a button vector.
import simon_pkg::*;

module button_debouncer #(
  parameter int unsigned CYCLES = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LED_W-1:0] raw,
  output logic [LED_W-1:0] stable
);

  localparam int unsigned CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

  logic [LED_W-1:0] sync1_q, sync1_d;
  logic [LED_W-1:0] sync2_q, sync2_d;
  logic [LED_W-1:0] cand_q, cand_d;
  logic [LED_W-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // cnt counts consecutive samples of cand; the vector is accepted on the
  // CYCLES-th sample, then the counter parks at CYCLES.
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    cand_d   = cand_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = CW'(1);
      if (CYCLES == 1) stable_d = sync2_q;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CNT_LAST) stable_d = cand_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/sequence_checker.sv
// Reads the stored pattern from memory and compares it with debounced button presses.
import simon_pkg::*;

module sequence_checker #(
  parameter int unsigned ms          = 1_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned TIMEOUT_MS  = 3000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] level,
  input  logic [LED_W-1:0]  btn,
  input  logic [VAL_W-1:0]  mem_data,
  output logic [ADDR_W-1:0] address,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [LED_W-1:0]  led_echo
);

  localparam int unsigned DB_CYCLES  = DEBOUNCE_MS * ms;
  localparam int unsigned TMO_CYCLES = TIMEOUT_MS * ms;
  localparam int unsigned TW         = $clog2(TMO_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);

  logic [LED_W-1:0] db_vec;

  button_debouncer #(.CYCLES(DB_CYCLES)) u_debouncer (
    .clk    (clk),
    .reset  (reset),
    .raw    (btn),
    .stable (db_vec)
  );

  chk_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] level_q, level_d;
  logic [VAL_W-1:0]  expected_q, expected_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              armed_q, armed_d;
  logic              load_q, load_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic [LED_W-1:0]  led_q, led_d;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    idx_d      = idx_q;
    level_d    = level_q;
    expected_d = expected_q;
    tmo_d      = tmo_q;
    armed_d    = armed_q;
    load_d     = load_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    led_d      = led_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          level_d = level;
          if (level == '0) begin
            state_d = ST_PASS;
          end else begin
            pass_d  = 1'b0;
            fail_d  = 1'b0;
            addr_d  = '0;
            idx_d   = '0;
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        tmo_d   = '0;
        armed_d = 1'b0;
        load_d  = 1'b1;
        state_d = ST_WAIT_PRESS;
      end
      ST_WAIT_PRESS: begin
        // mem_data is captured one cycle into this state so a registered
        // memory has seen the new address; no press can be accepted before.
        load_d = 1'b0;
        if (load_q) expected_d = mem_data;
        tmo_d = tmo_q + TW'(1);
        if (db_vec == '0) armed_d = 1'b1;
        if (armed_q && db_vec != '0) begin
          if (!$onehot(db_vec)) begin
            state_d = ST_FAIL;
          end else begin
            led_d   = db_vec;
            state_d = (onehot_index(db_vec) == expected_q) ? ST_WAIT_RELEASE : ST_FAIL;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_FAIL;
        end
      end
      ST_WAIT_RELEASE: begin
        if (db_vec == '0) begin
          led_d = '0;
          if (idx_q == level_q - ADDR_W'(1)) begin
            state_d = ST_PASS;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            addr_d  = idx_q + ADDR_W'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_PASS: state_d = ST_IDLE;
      ST_FAIL: begin
        led_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Result flags and done are registered on entry so they coincide with
    // the single PASS/FAIL cycle.
    if (state_d == ST_PASS) begin
      done_d = 1'b1;
      pass_d = 1'b1;
      fail_d = 1'b0;
    end else if (state_d == ST_FAIL) begin
      done_d = 1'b1;
      fail_d = 1'b1;
      pass_d = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      idx_q      <= '0;
      level_q    <= '0;
      expected_q <= '0;
      tmo_q      <= '0;
      armed_q    <= 1'b0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      idx_q      <= idx_d;
      level_q    <= level_d;
      expected_q <= expected_d;
      tmo_q      <= tmo_d;
      armed_q    <= armed_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      led_q      <= led_d;
    end
  end

  assign address  = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign led_echo = led_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Directed bench for sequence_checker with a registered pattern memory model.
module tb_sequence_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] level = '0;
  logic [3:0] btn = '0;
  logic [1:0] mem_data;
  logic [3:0] address;
  logic       busy, done, pass, fail;
  logic [3:0] led_echo;

  logic [1:0] mem [16];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int addr_log [$];

  sequence_checker #(.ms(10), .DEBOUNCE_MS(2), .TIMEOUT_MS(50)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .level    (level),
    .btn      (btn),
    .mem_data (mem_data),
    .address  (address),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail     (fail),
    .led_echo (led_echo)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = (i < 10) ? 2'(i % 4) : 2'd0;
  end

  always @(posedge clk) mem_data <= mem[address];

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy && (addr_log.size() == 0 || addr_log[$] != int'(address)))
      addr_log.push_back(int'(address));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [3:0] lvl);
    addr_log.delete();
    level = lvl;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic press(input logic [3:0] v, input int gap);
    btn = v;
    repeat (30) @(negedge clk);
    check("led_echo_hold", 32'(led_echo), 32'(v));
    repeat (10) @(negedge clk);
    btn = '0;
    repeat (gap) @(negedge clk);
  endtask

  // Counts negedges after the current one until done, up to limit.
  task automatic cycles_to_done(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
  endtask

  task automatic check_log(input string tag, input int exp [$]);
    check({tag, "_len"}, 32'(addr_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < addr_log.size(); i++)
      check(tag, 32'(addr_log[i]), 32'(exp[i]));
  endtask

  initial begin
    int n;
    int d0;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_address", 32'(address), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_fail", 32'(fail), 0);
    check("rst_led", 32'(led_echo), 0);

    // Correct three-entry sequence.
    d0 = done_cnt;
    pulse_start(4'd3);
    check("t1_busy", 32'(busy), 1);
    check("t1_addr0", 32'(address), 0);
    press(4'b0001, 40);
    press(4'b0010, 40);
    press(4'b0100, 40);
    check("t1_done_cnt", 32'(done_cnt - d0), 1);
    check("t1_pass", 32'(pass), 1);
    check("t1_fail", 32'(fail), 0);
    check("t1_busy_end", 32'(busy), 0);
    check_log("t1_addr", '{0, 1, 2});

    // Wrong second press: sync (2) + debounce (20) + FSM (1) = 23 cycles.
    pulse_start(4'd3);
    press(4'b0001, 40);
    btn = 4'b1000;
    cycles_to_done(60, n);
    check("t2_done_lat", 32'(n), 23);
    check("t2_fail", 32'(fail), 1);
    check("t2_pass", 32'(pass), 0);
    repeat (2) @(negedge clk);
    check("t2_led_clear", 32'(led_echo), 0);
    check("t2_addr", 32'(address), 1);
    check("t2_busy", 32'(busy), 0);
    btn = '0;
    repeat (30) @(negedge clk);

    // Timeout: FETCH (1) + FETCH->WAIT (1) + 500 waiting cycles.
    pulse_start(4'd2);
    cycles_to_done(600, n);
    check("t3_timeout_lat", 32'(n + 1), 502);
    check("t3_fail", 32'(fail), 1);
    @(negedge clk);
    check("t3_busy_drop", 32'(busy), 0);

    // Two buttons at once.
    pulse_start(4'd1);
    repeat (4) @(negedge clk);
    btn = 4'b0011;
    cycles_to_done(60, n);
    check("t4_multi_lat", 32'(n), 23);
    check("t4_multi_fail", 32'(fail), 1);
    btn = '0;
    repeat (30) @(negedge clk);

    // Single-cycle glitches must never register.
    d0 = done_cnt;
    pulse_start(4'd1);
    for (int i = 0; i < 20; i++) begin
      btn = 4'b0001;
      @(negedge clk);
      btn = '0;
      repeat (4) @(negedge clk);
    end
    check("t4_glitch_led", 32'(led_echo), 0);
    check("t4_glitch_busy", 32'(busy), 1);
    check("t4_glitch_done", 32'(done_cnt - d0), 0);
    press(4'b0001, 40);
    check("t4_glitch_pass", 32'(pass), 1);
    check("t4_glitch_done2", 32'(done_cnt - d0), 1);

    // Empty sequence passes immediately.
    pulse_start(4'd0);
    check("t5_l0_done", 32'(done), 1);
    check("t5_l0_pass", 32'(pass), 1);
    check("t5_l0_fail", 32'(fail), 0);
    @(negedge clk);
    check("t5_l0_done_off", 32'(done), 0);
    check("t5_l0_busy", 32'(busy), 0);

    // start while busy (with level=0 on the port) is ignored.
    d0 = done_cnt;
    pulse_start(4'd4);
    btn = 4'b0001;
    repeat (10) @(negedge clk);
    level = 4'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    check("t5_led_first", 32'(led_echo), 1);
    btn = '0;
    repeat (40) @(negedge clk);
    check("t5_no_restart", 32'(done_cnt - d0), 0);
    press(4'b0010, 40);
    press(4'b0100, 40);
    press(4'b1000, 40);
    check("t5_done_cnt", 32'(done_cnt - d0), 1);
    check("t5_pass", 32'(pass), 1);
    check_log("t5_addr", '{0, 1, 2, 3});

    // Reset while the button is held in WAIT_RELEASE.
    d0 = done_cnt;
    pulse_start(4'd3);
    btn = 4'b0001;
    n = 0;
    while (led_echo !== 4'b0001 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("t6_reach_release", 32'(led_echo), 1);
    reset = 1'b1;
    btn = '0;
    @(negedge clk);
    reset = 1'b0;
    check("t6_busy", 32'(busy), 0);
    check("t6_done", 32'(done), 0);
    check("t6_pass", 32'(pass), 0);
    check("t6_fail", 32'(fail), 0);
    check("t6_addr", 32'(address), 0);
    check("t6_led", 32'(led_echo), 0);
    repeat (30) @(negedge clk);
    check("t6_no_done", 32'(done_cnt - d0), 0);
    pulse_start(4'd1);
    check("t6_restart_addr", 32'(address), 0);
    press(4'b0001, 40);
    check("t6_restart_pass", 32'(pass), 1);
    check_log("t6_addr", '{0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sequence_checker.md
Name: sequence_checker

Overview:
- Player-input stage that sits directly downstream of the pattern memory, running alongside blinker.
- After blinker finishes showing a pattern, the game FSM pulses start.
- The block then reads the stored 2-bit values from mem, one address at a time, and compares each against a debounced button press.
- It reports pass or fail to the FSM with a one-cycle done pulse.

Parameters:
- ms, 1_000_000, clock cycles per millisecond (50 MHz clock = 50_000; benches use small values).
- DEBOUNCE_MS, 20, time a button vector must be stable before it is accepted.
- TIMEOUT_MS, 3000, maximum wait for each press before fail.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse from the FSM that begins a check; ignored unless IDLE.
- level  in  4  number of entries to check (0..15).
- btn  in  4  raw buttons, active-high pressed (top level inverts KEY); asynchronous to clk.
- mem_data  in  2  mem out_num; valid 1 cycle after address changes.
- address  out  4  mem read address (the memory's rw is held 0 by the top level during checking).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a check ends.
- pass  out  1  result flag; held until the next accepted start or reset.
- fail  out  1  result flag; held until the next accepted start or reset.
- led_echo  out  4  debounced accepted press, shown on LEDs while the button is held.

Behaviour:
- Reset: state IDLE; address=0; busy, done, pass, fail = 0; led_echo=0; counters=0; debouncer cleared. Reset mid-operation aborts immediately with no done pulse.
- Input conditioning:
  - btn goes through a 2-FF synchroniser, then the debouncer.
  - The debounced vector updates only after the synchronised vector has been unchanged for DEBOUNCE_MS*ms consecutive cycles.
  - Any change restarts the stable count.
- State IDLE:
  - start=1 with level=0: go to PASS (empty sequence passes).
  - start=1 otherwise: clear pass/fail, set address=0, idx=0, go to FETCH.
- State FETCH (1 cycle): waits out the mem read latency. Next cycle: expected<=mem_data, timeout counter cleared, go to WAIT_PRESS.
- State WAIT_PRESS:
  - The timeout counter increments every cycle.
  - Reaching TIMEOUT_MS*ms without a press: go to FAIL.
  - A rising change of the debounced vector from 0000 to non-zero is a press:
    - more than one bit set: go to FAIL;
    - one-hot bit k (k=0..3 maps to value 0..3): led_echo<=vector, then k==expected goes to WAIT_RELEASE, otherwise FAIL.
- State WAIT_RELEASE:
  - Waits until the debounced vector is 0000, then clears led_echo.
  - If idx==level-1: go to PASS.
  - Else idx<=idx+1, address<=idx+1, go to FETCH.
  - There is no timeout while the button is held.
- State PASS (1 cycle): done=1, pass<=1, go to IDLE.
- State FAIL (1 cycle): done=1, fail<=1, led_echo<=0, go to IDLE.
- pass and fail are never both 1. done is high for exactly one cycle per check.
- level is sampled at start and held internally; later changes have no effect.
- address wrap: idx never exceeds 14, because the last index is level-1 ≤ 14, so address never wraps.
- start while busy is ignored.
- A button already held when start arrives is not a press. The vector must first be seen at 0000 in WAIT_PRESS.

Decomposition:
- Package simon_pkg holds:
  - the checker state enum (IDLE, FETCH, WAIT_PRESS, WAIT_RELEASE, PASS, FAIL);
  - LED_W=4, VAL_W=2, ADDR_W=4.
- One sub-module: button_debouncer #(CYCLES), with ports clk, reset, raw[3:0], stable[3:0]. It contains the synchroniser and the stable counter.

Test Plan (ms=10, DEBOUNCE_MS=2, TIMEOUT_MS=50; mem preloaded with 0,1,2,3,0,1,2,3,0,1):
- level=3; press btn 0001, 0010, 0100, each held 40 cycles with 40-cycle gaps -> addresses 0,1,2 visited in order; led_echo mirrors each press; done pulse with pass=1, fail=0.
- level=3; second press is 1000 -> fail=1 and done one cycle after the debounced press; led_echo=0; address stays 1.
- level=2; no press for 500 cycles after FETCH -> fail=1 and done at timeout; busy drops the next cycle.
- level=1; btn 0011 pressed together -> fail=1; btn glitches of 1-cycle pulses every 5 cycles -> no press accepted.
- level=0 start -> done the cycle after start with pass=1; start pulsed while busy during a level=4 run -> no restart, and the run completes normally.
- Reset asserted in WAIT_RELEASE -> next cycle busy=0, done=0, pass=0, fail=0, address=0; a following start runs from address 0.
